// File: rtl/conv_window_reader.sv
// Sliding KxK window generator fed by a raster pixel stream.
// K-1 row-deep shift buffers supply the older rows, and a KxK register array holds the current window.
// A window is emitted for every valid-padding output position.
module conv_window_reader #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned K      = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic [DATA_W-1:0]           data_i,
    output logic                        win_valid_o,
    output logic [K*K*DATA_W-1:0]       window_o,
    output logic [$clog2(IMG_H)-1:0]    win_row_o,
    output logic [$clog2(IMG_W)-1:0]    win_col_o,
    output logic                        frame_done_o
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = K * K * DATA_W;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic               last_col;
    logic               last_row;
    logic               fire;
    logic               done;

    logic [DATA_W-1:0]  lb [K-1][IMG_W];
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   win_d;

    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));

    // Next state plus window-emit decision for the pixel being accepted
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        done    = 1'b0;
        case (state_q)
            FILL: begin
                if (valid_i && last_col && (row_q == ROW_W'(K - 2))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                fire = valid_i && (col_q >= COL_W'(K - 1));
                done = fire && last_col && last_row;
                if (valid_i && last_col && last_row) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Window contents after shifting in the accepted pixel and the line-buffer taps
    always_comb begin
        win_d = win_q;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_d[(r*K + c)*DATA_W +: DATA_W] = win_q[(r*K + c + 1)*DATA_W +: DATA_W];
            end
        end
        win_d[((K-1)*K + K - 1)*DATA_W +: DATA_W] = data_i;
        for (int unsigned j = 0; j < K - 1; j++) begin
            win_d[((K-2-j)*K + K - 1)*DATA_W +: DATA_W] = lb[j][IMG_W-1];
        end
    end

    // State register and raster position counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (valid_i) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    // Registered window outputs; the payload and indices hold between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            window_o     <= '0;
            win_row_o    <= '0;
            win_col_o    <= '0;
        end else begin
            win_valid_o  <= fire;
            frame_done_o <= done;
            if (fire) begin
                window_o  <= win_d;
                win_row_o <= row_q - ROW_W'(K - 1);
                win_col_o <= col_q - COL_W'(K - 1);
            end
        end
    end

    // Data storage is never cleared; the row/column gating hides stale contents
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            win_q    <= win_d;
            lb[0][0] <= data_i;
            for (int unsigned j = 1; j < K - 1; j++) begin
                lb[j][0] <= lb[j-1][IMG_W-1];
            end
            for (int unsigned j = 0; j < K - 1; j++) begin
                for (int unsigned i = 1; i < IMG_W; i++) begin
                    lb[j][i] <= lb[j][i-1];
                end
            end
        end
    end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read side of the 12-bit line-buffer shift chain used between CNN layers.
- Consumes a raster-ordered signed pixel stream, one pixel per accepted beat.
- Internally keeps K-1 row-length shift buffers plus a KxK window register array.
- Emits one fully-populated KxK window per valid output position (valid-padding convolution) to the downstream MAC array.

Parameters:
- DATA_W, 12, signed pixel width.
- IMG_W, 16, pixels per row; also the depth of each internal line buffer; must be >= K.
- IMG_H, 16, rows per frame; must be >= K.
- K, 3, window edge length; must be >= 2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  pixel beat valid; no backpressure, every asserted cycle is consumed.
- data_i  in  DATA_W  signed pixel, raster order: row 0 col 0 first.
- win_valid_o  out  1  window_o holds a new window this cycle (1-cycle pulse per window).
- window_o  out  K*K*DATA_W  flattened window; element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column.
- win_row_o  out  $clog2(IMG_H)  output row index of window = pixel row - (K-1).
- win_col_o  out  $clog2(IMG_W)  output col index of window = pixel col - (K-1).
- frame_done_o  out  1  pulses with the last window of a frame.

Behaviour:
- Reset: col/row counters=0, state=FILL; win_valid_o=0, frame_done_o=0, win_row_o=0, win_col_o=0, window_o=0.
- Line buffer and window storage contents need not be cleared. Stale data is never exposed because the valid gating requires K-1 fresh rows and K fresh columns.
- Line buffers: K-1 chained shift buffers, each IMG_W deep, advanced only on valid_i.
  - Buffer 0 takes data_i; buffer j takes the output of buffer j-1.
  - Tap of buffer j = pixel at the same column, j+1 rows earlier.
- Window array: on valid_i each window row shifts left one column.
  - Column K-1 loads (row r): r=K-1 gets data_i; r=K-2-j gets tap of buffer j.
- Counters: col increments on valid_i; at IMG_W-1 it wraps to 0 and row increments. At row IMG_H-1, col IMG_W-1 both wrap to 0 and the next frame starts immediately (no idle cycle required).
- States:
  - FILL: row < K-1.
  - RUN: row >= K-1.
  - FILL->RUN on acceptance of the last pixel of row K-2.
  - RUN->FILL on acceptance of the last pixel of the frame.
- Output rule:
  - If valid_i, state RUN, and col >= K-1 at acceptance, then next cycle win_valid_o=1 and window_o holds the completed window.
  - win_row_o/win_col_o are set from row-(K-1) and col-(K-1).
  - Latency: 1 cycle from accepting the window's bottom-right pixel.
- frame_done_o=1 in the same cycle as win_valid_o for window (IMG_H-K, IMG_W-K); 0 otherwise.
- valid_i low: nothing shifts, counters and state hold, win_valid_o=0 next cycle. window_o/indices hold their last values.
- Windows per frame = (IMG_H-K+1)*(IMG_W-K+1).
- No window straddles rows: col < K-1 at acceptance produces no output.
- Data passes bit-exact; no arithmetic and no sign extension.
- rst_i mid-frame: same state as power-on reset next cycle. A pulse already in flight is suppressed (outputs 0 the cycle after rst_i). The pixel presented with rst_i high is discarded. The next accepted pixel is row 0 col 0.

Test Plan:
- IMG_W=4, IMG_H=4, K=3, continuous valid_i, pixel = 4*row+col:
  - First win_valid_o one cycle after pixel 10.
  - window_o (r,c) = {0,1,2,4,5,6,8,9,10}; win_row_o=0, win_col_o=0.
  - Exactly 4 windows; last is {5,6,7,9,10,11,13,14,15} with frame_done_o=1.
- Same stream with valid_i low every other cycle -> identical window sequence and contents, each pulse one cycle after its pixel; no pulses during gaps.
- Two back-to-back frames with second-frame pixels = 100+index:
  - The second frame's first window is {100,101,102,104,105,106,108,109,110}.
  - No window mixes frames; 8 pulses total.
- rst_i asserted at pixel 9 of frame 1, then a fresh frame -> no window from the aborted frame. Fresh frame output matches the first scenario exactly.
- Pixels -2048 and 2047 at positions 0 and 10 -> window_o elements (0,0)=12'h800 and (2,2)=12'h7FF, bit-exact.
- Default parameters, 256-pixel frame -> 196 pulses and one frame_done_o. Last window indices are row 13, col 13.
